ex_acc_alu_core: RTL and testbench



---
 rtl/ex_acc_alu_core.sv | 86 ++++++++
 tb/tb_ex_acc_alu_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ex_acc_alu_core.sv
// ============================================================================
// Module  : ex_acc_alu_core
// Brief   : Execute-stage core: accumulator-control decode, registered ALU
//           with zero flag, and registered branch-target adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_acc_alu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             jump,
  input  logic             jump_c,
  input  logic             sin,
  input  logic             in_a,
  input  logic             two_and_one,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic             mux_sel_imm,
  output logic             ac_load,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_zero,
  output logic [WIDTH-1:0] jump_target
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic             alu_zero_d, alu_zero_q;
  logic [WIDTH-1:0] jump_target_d, jump_target_q;
  logic [2:0]       shamt;

  // Jumps never load the input accumulator; an immediate load wins over sin.
  assign mux_sel_imm = in_a;
  assign ac_load     = ~jump & ~jump_c & (in_a | (sin & ~two_and_one));

  assign shamt = op_b[2:0];

  always_comb begin
    alu_result_d = '0;
    case (alu_op)
      OP_ADD:  alu_result_d = op_a + op_b;
      OP_SUB:  alu_result_d = op_a - op_b;
      OP_AND:  alu_result_d = op_a & op_b;
      OP_OR:   alu_result_d = op_a | op_b;
      OP_XOR:  alu_result_d = op_a ^ op_b;
      OP_NOT:  alu_result_d = ~op_a;
      OP_SHL:  alu_result_d = op_a << shamt;
      OP_SHR:  alu_result_d = op_a >> shamt;
      default: alu_result_d = '0;
    endcase
    alu_zero_d    = (alu_result_d == '0);
    jump_target_d = pc + imm;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q  <= '0;
      alu_zero_q    <= 1'b0;
      jump_target_q <= '0;
    end else begin
      alu_result_q  <= alu_result_d;
      alu_zero_q    <= alu_zero_d;
      jump_target_q <= jump_target_d;
    end
  end

  assign alu_result  = alu_result_q;
  assign alu_zero    = alu_zero_q;
  assign jump_target = jump_target_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_acc_alu_core.sv
// ============================================================================
// Module  : tb_ex_acc_alu_core
// Brief   : Self-checking bench for ex_acc_alu_core against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_acc_alu_core;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       jump = 1'b0, jump_c = 1'b0, sin = 1'b0, in_a = 1'b0, two_and_one = 1'b0;
  logic [2:0] alu_op = 3'd0;
  logic [7:0] op_a = 8'h00, op_b = 8'h00, pc = 8'h00, imm = 8'h00;
  logic       mux_sel_imm, ac_load, alu_zero;
  logic [7:0] alu_result, jump_target;

  int n_assert = 0;
  int n_fail   = 0;

  ex_acc_alu_core #(.WIDTH(8)) dut (
    .clock(clock), .rst_n(rst_n), .jump(jump), .jump_c(jump_c), .sin(sin),
    .in_a(in_a), .two_and_one(two_and_one), .alu_op(alu_op), .op_a(op_a),
    .op_b(op_b), .pc(pc), .imm(imm), .mux_sel_imm(mux_sel_imm),
    .ac_load(ac_load), .alu_result(alu_result), .alu_zero(alu_zero),
    .jump_target(jump_target)
  );

  always #5 clock = ~clock;

  // Reference model: plain integer arithmetic on 0..255 values.
  function automatic int model_alu(input int op, input int a, input int b);
    int s;
    s = b % 8;
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 255 - a;
      6: return (a * (1 << s)) % 256;
      default: return a / (1 << s);
    endcase
  endfunction

  function automatic int model_ac_load(input int j, input int jc, input int s,
                                       input int ia, input int t);
    if (j != 0 || jc != 0) return 0;
    if (ia != 0) return 1;
    if (s != 0 && t == 0) return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one ALU/jump operation after a falling edge, check one cycle later.
  task automatic alu_step(input string tag, input int op, input int a, input int b,
                          input int p, input int i);
    int exp_r;
    @(negedge clock);
    alu_op = 3'(op); op_a = 8'(a); op_b = 8'(b); pc = 8'(p); imm = 8'(i);
    exp_r = model_alu(op, a, b);
    @(posedge clock); #1;
    check({tag, "_result"}, int'(alu_result), exp_r);
    check({tag, "_zero"}, int'(alu_zero), (exp_r == 0) ? 1 : 0);
    check({tag, "_jt"}, int'(jump_target), (p + i) % 256);
  endtask

  task automatic ctrl_step(input string tag, input int j, input int jc, input int s,
                           input int ia, input int t);
    jump = 1'(j); jump_c = 1'(jc); sin = 1'(s); in_a = 1'(ia); two_and_one = 1'(t);
    #1;
    check({tag, "_ac_load"}, int'(ac_load), model_ac_load(j, jc, s, ia, t));
    check({tag, "_mux_sel"}, int'(mux_sel_imm), ia);
  endtask

  initial begin
    int exp_prev, exp_cur;

    // Reset held from time zero with nonzero inputs.
    op_a = 8'h5A; op_b = 8'h33; pc = 8'h44; imm = 8'h11; alu_op = 3'd0;
    #1;
    check("rst_result", int'(alu_result), 0);
    check("rst_zero", int'(alu_zero), 0);
    check("rst_jt", int'(jump_target), 0);
    @(posedge clock); #1;
    check("rst_hold_result", int'(alu_result), 0);
    check("rst_hold_jt", int'(jump_target), 0);
    @(negedge clock);
    rst_n = 1'b1;

    // Directed ALU cases.
    alu_step("add_wrap", 0, 8'hF0, 8'h20, 8'hFE, 8'h05);
    alu_step("add_zero", 0, 8'h80, 8'h80, 8'h10, 8'hFE);
    alu_step("sub", 1, 8'h05, 8'h07, 0, 0);
    alu_step("and", 2, 8'hCC, 8'hAA, 0, 0);
    alu_step("or", 3, 8'hC0, 8'h0A, 0, 0);
    alu_step("xor_zero", 4, 8'hCC, 8'hCC, 0, 0);
    alu_step("shl", 6, 8'h81, 8'h01, 0, 0);
    alu_step("shr", 7, 8'h81, 8'h07, 0, 0);
    alu_step("not", 5, 8'h0F, 8'h00, 0, 0);
    alu_step("shl_b_high", 6, 8'h01, 8'hFB, 0, 0);

    // Jump target only moves on the rising edge.
    alu_step("jt_a", 0, 1, 1, 8'hFE, 8'h05);
    @(negedge clock);
    pc = 8'h10; imm = 8'hFE;
    #1;
    check("jt_before_edge", int'(jump_target), 8'h03);
    @(posedge clock); #1;
    check("jt_after_edge", int'(jump_target), 8'h0E);

    // Back-to-back ops: each result lands exactly one cycle after its inputs.
    exp_prev = model_alu(0, 8'h10, 8'hFE);
    exp_prev = int'(alu_result);
    for (int op = 0; op < 8; op++) begin
      @(negedge clock);
      alu_op = 3'(op); op_a = 8'h3C; op_b = 8'h02;
      exp_cur = model_alu(op, 8'h3C, 8'h02);
      #1;
      check($sformatf("b2b_hold_%0d", op), int'(alu_result), exp_prev);
      @(posedge clock); #1;
      check($sformatf("b2b_op_%0d", op), int'(alu_result), exp_cur);
      exp_prev = exp_cur;
    end

    // Control decode: directed then exhaustive.
    ctrl_step("ctl_in_a", 0, 0, 0, 1, 0);
    ctrl_step("ctl_sin", 0, 0, 1, 0, 0);
    ctrl_step("ctl_sin_two", 0, 0, 1, 0, 1);
    ctrl_step("ctl_in_a_jump", 1, 0, 0, 1, 0);
    ctrl_step("ctl_in_a_jumpc", 0, 1, 0, 1, 0);
    ctrl_step("ctl_in_a_sin", 0, 0, 1, 1, 0);
    ctrl_step("ctl_zero", 0, 0, 0, 0, 0);
    for (int v = 0; v < 32; v++)
      ctrl_step($sformatf("ctl_all_%0d", v), (v >> 4) & 1, (v >> 3) & 1,
                (v >> 2) & 1, (v >> 1) & 1, v & 1);

    // Randomized operations.
    for (int n = 0; n < 200; n++)
      alu_step($sformatf("rnd_%0d", n), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    // Reset asserted mid-operation clears outputs without an edge.
    alu_step("pre_rst", 0, 8'h12, 8'h34, 8'h20, 8'h22);
    @(negedge clock);
    op_a = 8'h77; op_b = 8'h01; alu_op = 3'd0; in_a = 1'b1; jump = 1'b0; jump_c = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_result", int'(alu_result), 0);
    check("midrst_zero", int'(alu_zero), 0);
    check("midrst_jt", int'(jump_target), 0);
    check("midrst_ac_load", int'(ac_load), 1);
    check("midrst_mux_sel", int'(mux_sel_imm), 1);
    @(posedge clock); #1;
    check("midrst_edge_result", int'(alu_result), 0);
    @(negedge clock);
    rst_n = 1'b1;
    alu_step("post_rst", 4, 8'hA5, 8'h0F, 8'h01, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
